// File: rtl/sext_narrow_if.sv
// sext_narrow handshake bundle.
// Input word channel, result channel and overflow counter.
interface sext_narrow_if #(
  parameter int WIDTH = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_field;
  logic             out_fits;
  logic             out_sat;
  logic [7:0]       ovf_count;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sat_en,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_field,
    output out_fits,
    output out_sat,
    output ovf_count
  );

  modport master (
    output in_valid,
    output in_data,
    output in_sat_en,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_field,
    input  out_fits,
    input  out_sat,
    input  ovf_count
  );
endinterface

// File: rtl/sext_narrow.sv
// sext_narrow: two-stage 16-bit to WIDTH-bit narrowing unit.
// Flags unrepresentable values, optionally saturates them.
module sext_narrow #(
  parameter int WIDTH = 5
) (
  input  logic          clk_50,
  input  logic          reset,
  sext_narrow_if.slave  bus
);

  localparam logic [WIDTH-1:0] SAT_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_s1_valid;
  logic [15:0]      r_s1_data;
  logic             r_s1_sat_en;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_field;
  logic             r_fits;
  logic             r_sat;
  logic [7:0]       r_ovf;

  logic             w_out_xfer;
  logic             w_s2_load;
  logic             w_s1_move;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic [16-WIDTH:0] w_hi;
  logic             w_fits;
  logic [WIDTH-1:0] w_field;
  logic             w_sat;

  // Pipeline advance conditions; in_ready sees out_ready combinationally.
  always_comb begin
    w_out_xfer = r_s2_valid && bus.out_ready;
    w_s2_load  = !r_s2_valid || w_out_xfer;
    w_s1_move  = r_s1_valid && w_s2_load;
    w_in_ready = !r_s1_valid || w_s1_move;
    w_in_xfer  = bus.in_valid && w_in_ready;
  end

  // Fit test and truncate/saturate selection on the S1 word.
  always_comb begin
    w_hi    = r_s1_data[15:WIDTH-1];
    w_fits  = (&w_hi) || !(|w_hi);
    w_field = r_s1_data[WIDTH-1:0];
    w_sat   = 1'b0;
    if (!w_fits && r_s1_sat_en) begin
      w_sat   = 1'b1;
      w_field = r_s1_data[15] ? SAT_NEG : SAT_POS;
    end
  end

  // S1: capture the accepted word.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_sat_en <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_valid  <= 1'b1;
      r_s1_data   <= bus.in_data;
      r_s1_sat_en <= bus.in_sat_en;
    end else if (w_s1_move) begin
      r_s1_valid  <= 1'b0;
    end
  end

  // S2: result register, held while the consumer stalls.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_field    <= '0;
      r_fits     <= 1'b0;
      r_sat      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_field <= w_field;
        r_fits  <= w_fits;
        r_sat   <= w_sat;
      end
    end
  end

  // Count delivered unrepresentable results, sticking at 255.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_ovf <= '0;
    end else if (w_out_xfer && !r_fits && r_ovf != 8'hFF) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_field = r_field;
  assign bus.out_fits  = r_fits;
  assign bus.out_sat   = r_sat;
  assign bus.ovf_count = r_ovf;

endmodule

// File: doc/sext_narrow.md
# sext_narrow

Pipelined narrowing unit for the LC-3b datapath; the inverse of the sign-extension path. It accepts a 16-bit two's-complement value and produces a WIDTH-bit immediate field, flagging whether the value is representable. It optionally saturates unrepresentable values to the field limits. It sits between the ALU/address result path and the instruction-field packer and assembler-check logic, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 5: output field width in bits; legal range 2..15.

- clk_50  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept the input word this cycle.
- in_data  in  16  two's-complement value to narrow.
- in_sat_en  in  1  saturate-on-overflow request, sampled with in_data.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_field  out  WIDTH  narrowed field.
- out_fits  out  1  1 = in_data is representable in WIDTH signed bits.
- out_sat  out  1  1 = out_field was saturated rather than truncated.
- ovf_count  out  8  count of delivered results with out_fits=0; saturates at 255.

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1) registers in_data and in_sat_en and computes fits.
  - fits = 1 when in_data[15:WIDTH-1] are all equal (all 0s or all 1s).
- Stage 2 (S2) registers the result:
  - If fits=1, or fits=0 with sat_en=0: out_field = in_data[WIDTH-1:0] (wrap/truncate), out_sat = 0.
  - If fits=0 with sat_en=1:
    - in_data[15]=0 (positive overflow): out_field = {0, all 1s} = 2^(WIDTH-1)-1.
    - in_data[15]=1 (negative overflow): out_field = {1, all 0s} = -2^(WIDTH-1).
    - out_sat = 1 in both cases.
  - out_fits carries fits.
- Each stage holds a valid bit. S2 loads when it is empty or its output transfers this cycle. S1 loads when it is empty or it moves into S2 this cycle.
- in_ready = !S1.valid || (S1 moves into S2 this cycle). This is a combinational path from out_ready and is allowed.
- Results emerge in acceptance order; nothing is dropped or duplicated.
- While out_valid && !out_ready, out_field, out_fits and out_sat are held stable.
- ovf_count increments by 1 on each output transfer with out_fits=0 and holds at 255.
- in_sat_en does not affect ovf_count.

## Timing
- Reset (synchronous, while reset=1 at a clock edge):
  - both valid bits clear, so out_valid=0 and in_ready=1 in the following cycle;
  - out_field=0, out_fits=0, out_sat=0, ovf_count=0.
- Reset mid-operation discards in-flight words. An input transfer in the same cycle as reset is ignored.
- Latency: a word accepted at edge N gives out_valid=1 after edge N+1 (S1 loads at N, S2 at N+1). The result is visible the cycle after N+1 when out_ready is held high.
- Throughput: 1 word per cycle with out_ready=1 continuously.
- Backpressure: with out_ready=0, at most 2 words are buffered. in_ready drops when S1 and S2 are both full.
- Simultaneous input and output transfer with both stages full is allowed: all stages shift and no bubble is inserted.
- ovf_count updates on the edge of the output transfer.

## Test plan
- WIDTH=5, in_data=0x000F, sat_en=0 -> out_field=0x0F, fits=1, sat=0, arriving 2 cycles after acceptance.
- in_data=0x0010 with sat_en=0 -> field=0x10, fits=0, sat=0. Then with sat_en=1 -> field=0x0F, fits=0, sat=1. ovf_count=2.
- in_data=0xFFF0 -> field=0x10, fits=1. in_data=0xFFEF with sat_en=1 -> field=0x10, sat=1. in_data=0x8000 with sat_en=1 -> field=0x10, sat=1.
- Backpressure:
  - Hold out_ready=0 and offer 4 words: exactly 2 accepted, in_ready=0, output stable.
  - Release out_ready: words appear in order and the remaining 2 are accepted, with no bubbles.
- 300 back-to-back overflowing words (0x0100) -> ovf_count reaches 255 and stays at 255.
- Assert reset for 1 cycle with both stages full -> out_valid=0, in_ready=1, ovf_count=0 next cycle. The word offered during reset is never output.
